// File: rtl/bit_serializer_if.sv
// Word handshake plus serial-bit outputs exchanged between a word producer and bit_serializer.
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_i;
    logic             valid_i;
    logic             ready_o;
    logic             bit_o;
    logic             bit_valid_o;
    logic             last_o;

    modport master (
        output data_i, valid_i,
        input  ready_o, bit_o, bit_valid_o, last_o
    );

    modport slave (
        input  data_i, valid_i,
        output ready_o, bit_o, bit_valid_o, last_o
    );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: one WIDTH-bit word in over valid/ready, one bit out per clock,
// with a one-entry holding buffer so consecutive words stream without idle cycles.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk_c,
    input  logic             reset_r,
    bit_serializer_if.slave  bus
);
    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sh, sh_nxt;
    logic [WIDTH-1:0] hold, hold_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             hold_v, hold_v_nxt;
    logic             accept;
    logic             at_last;
    logic             busy;
    logic [WIDTH-1:0] sh_shifted;

    assign bus.ready_o = !hold_v;
    assign accept      = bus.valid_i & !hold_v;
    assign at_last     = (cnt == LAST_IDX);
    assign busy        = (state == SHIFT);
    assign sh_shifted  = LSB_FIRST ? (sh >> 1) : (sh << 1);

    assign bus.bit_valid_o = busy;
    assign bus.bit_o       = busy ? (LSB_FIRST ? sh[0] : sh[WIDTH-1]) : 1'b0;
    assign bus.last_o      = busy & at_last;

    always_ff @(posedge clk_c or posedge reset_r) begin
        if (reset_r) begin
            state  <= IDLE;
            sh     <= '0;
            cnt    <= '0;
            hold   <= '0;
            hold_v <= 1'b0;
        end else begin
            state  <= state_nxt;
            sh     <= sh_nxt;
            cnt    <= cnt_nxt;
            hold   <= hold_nxt;
            hold_v <= hold_v_nxt;
        end
    end

    // On the last bit a held word takes priority; otherwise a word arriving that cycle loads directly.
    always_comb begin
        state_nxt  = state;
        sh_nxt     = sh;
        cnt_nxt    = cnt;
        hold_nxt   = hold;
        hold_v_nxt = hold_v;
        case (state)
            IDLE: begin
                if (accept) begin
                    sh_nxt    = bus.data_i;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (!at_last) begin
                    sh_nxt  = sh_shifted;
                    cnt_nxt = cnt + CNT_W'(1);
                    if (accept) begin
                        hold_nxt   = bus.data_i;
                        hold_v_nxt = 1'b1;
                    end
                end else if (hold_v) begin
                    sh_nxt     = hold;
                    hold_v_nxt = 1'b0;
                    cnt_nxt    = '0;
                end else if (accept) begin
                    sh_nxt  = bus.data_i;
                    cnt_nxt = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
